// File: rtl/opendap_mem_ap_ahbl.sv
// MEM-AP bridging DP register accesses onto a single-master AHB-Lite bus.
// Local registers (CSW/TAR/ID) complete in one cycle; DRW/BDn launch one NONSEQ transfer.
module opendap_mem_ap_ahbl #(
  parameter logic [7:0]  APSEL = 8'd0,
  parameter logic [31:0] IDR   = 32'h0477_0001,
  parameter logic [31:0] BASE  = 32'hffff_ffff
) (
  input  logic        swclk,
  input  logic        rst_n,
  input  logic [7:0]  ap_sel,
  input  logic [5:0]  ap_addr,
  input  logic [31:0] ap_wdata,
  input  logic        ap_wen,
  input  logic        ap_ren,
  output logic [31:0] ap_rdata,
  output logic        ap_rdy,
  output logic        ap_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [5:0] A_CSW  = 6'h00;
  localparam logic [5:0] A_TAR  = 6'h01;
  localparam logic [5:0] A_DRW  = 6'h03;
  localparam logic [5:0] A_BASE = 6'h3E;
  localparam logic [5:0] A_IDR  = 6'h3F;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t          r_state;
  logic [2:0]      r_size;
  logic [1:0]      r_inc;
  logic [DW-1:0]   r_tar;
  logic [DW-1:0]   r_rdata;
  logic            r_rdy;
  logic            r_err;
  logic            r_drw;
  logic [DW-1:0]   r_haddr;
  logic [1:0]      r_htrans;
  logic            r_hwrite;
  logic [2:0]      r_hsize;
  logic [DW-1:0]   r_hwdata;

  logic            w_acc;
  logic            w_is_drw;
  logic            w_is_bd;
  logic [2:0]      w_wsize;
  logic [DW-1:0]   w_csw;
  logic [DW-1:0]   w_tar_inc;
  logic [DW-1:0]   w_rd_local;

  assign w_acc     = r_rdy && (ap_wen || ap_ren) && (ap_sel == APSEL);
  assign w_is_drw  = (ap_addr == A_DRW);
  assign w_is_bd   = (ap_addr[5:2] == 4'b0001);
  assign w_wsize   = (ap_wdata[2:0] > 3'd2) ? 3'd2 : ap_wdata[2:0];
  assign w_csw     = {24'd0, ~r_rdy, 1'b1, r_inc, 1'b0, r_size};
  assign w_tar_inc = r_tar + (DW'(1) << r_size);

  // Read mux for registers answered without bus activity
  always_comb begin
    w_rd_local = '0;
    case (ap_addr)
      A_CSW:   w_rd_local = w_csw;
      A_TAR:   w_rd_local = r_tar;
      A_BASE:  w_rd_local = BASE;
      A_IDR:   w_rd_local = IDR;
      default: w_rd_local = '0;
    endcase
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_size   <= 3'd0;
      r_inc    <= 2'd0;
      r_tar    <= '0;
      r_rdata  <= '0;
      r_rdy    <= 1'b1;
      r_err    <= 1'b0;
      r_drw    <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'd0;
      r_hwdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_err <= 1'b0;
            if (w_is_drw || w_is_bd) begin
              r_state  <= S_ADDR;
              r_rdy    <= 1'b0;
              r_drw    <= w_is_drw;
              r_htrans <= HTRANS_NONSEQ;
              r_hwrite <= ap_wen;
              r_hwdata <= ap_wdata;
              if (w_is_drw) begin
                r_haddr <= r_tar;
                r_hsize <= r_size;
              end else begin
                r_haddr <= {r_tar[31:4], ap_addr[1:0], 2'b00};
                r_hsize <= 3'd2;
              end
            end else if (ap_wen) begin
              if (ap_addr == A_CSW) begin
                r_size <= w_wsize;
                r_inc  <= ap_wdata[5:4];
              end
              if (ap_addr == A_TAR) r_tar <= ap_wdata;
            end else begin
              r_rdata <= w_rd_local;
            end
          end
        end
        S_ADDR: begin
          if (hready) begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (hready) begin
            if (!r_hwrite) r_rdata <= hrdata;
            r_err   <= hresp;
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
            // Auto-increment only for successful DRW with AddrInc single
            if (r_drw && !hresp && (r_inc == 2'b01)) r_tar <= w_tar_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ap_rdata = r_rdata;
  assign ap_rdy   = r_rdy;
  assign ap_err   = r_err;
  assign haddr    = r_haddr;
  assign htrans   = r_htrans;
  assign hwrite   = r_hwrite;
  assign hsize    = r_hsize;
  assign hwdata   = r_hwdata;

endmodule

// File: tb/tb_opendap_mem_ap_ahbl.sv
// Scoreboard bench for opendap_mem_ap_ahbl: expected AHB transfers and AP results are
// queued at request time; a slave process pops transfers, the request task pops results.
module tb_opendap_mem_ap_ahbl;

  localparam logic [7:0]  APSEL = 8'h05;
  localparam logic [31:0] IDR   = 32'h0477_0001;
  localparam logic [31:0] BASE  = 32'hffff_ffff;

  logic        swclk = 1'b0;
  logic        rst_n;
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata;
  logic        ap_wen;
  logic        ap_ren;
  logic [31:0] ap_rdata;
  logic        ap_rdy;
  logic        ap_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    int          ws;
    logic [31:0] rd;
    logic        err;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_rd = 32'd0;
  bit   g_abort = 1'b0;

  opendap_mem_ap_ahbl #(.APSEL(APSEL), .IDR(IDR), .BASE(BASE)) dut (
    .swclk(swclk), .rst_n(rst_n), .ap_sel(ap_sel), .ap_addr(ap_addr),
    .ap_wdata(ap_wdata), .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_rdata(ap_rdata),
    .ap_rdy(ap_rdy), .ap_err(ap_err), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  always #5 swclk = ~swclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [2:0] s, input logic w,
                          input logic [31:0] wd, input int ws, input logic [31:0] rd,
                          input logic e);
    bus_t b;
    b.addr = a; b.size = s; b.wr = w; b.wdata = wd; b.ws = ws; b.rd = rd; b.err = e;
    bus_q.push_back(b);
  endtask

  // Issue one request at a negedge; returns at the negedge where ap_rdy is back high
  task automatic do_req(input string tag, input logic [7:0] sel, input logic [5:0] a,
                        input logic wen, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input bit local_acc);
    res_t r;
    int   n;
    r.rdata = exp_rd; r.err = exp_err;
    res_q.push_back(r);
    ap_sel = sel; ap_addr = a; ap_wen = wen; ap_ren = !wen; ap_wdata = wd;
    @(negedge swclk);
    ap_wen = 1'b0; ap_ren = 1'b0;
    if (local_acc) begin
      check({tag, ".rdy_stay"}, 32'(ap_rdy), 32'd1);
      check({tag, ".htrans_idle"}, 32'(htrans), 32'd0);
    end
    n = 0;
    while (!ap_rdy && n < 100) begin
      @(negedge swclk);
      n++;
    end
    check({tag, ".done"}, 32'(ap_rdy), 32'd1);
    r = res_q.pop_front();
    check({tag, ".rdata"}, ap_rdata, r.rdata);
    check({tag, ".err"}, 32'(ap_err), 32'(r.err));
  endtask

  task automatic wr_loc(input string tag, input logic [5:0] a, input logic [31:0] d);
    do_req(tag, APSEL, a, 1'b1, d, m_rd, 1'b0, 1'b1);
  endtask

  task automatic rd_loc(input string tag, input logic [5:0] a, input logic [31:0] exp);
    m_rd = exp;
    do_req(tag, APSEL, a, 1'b0, 32'd0, exp, 1'b0, 1'b1);
  endtask

  // AHB slave: pops the expected transfer when NONSEQ appears and plays its response
  initial begin : slave
    bus_t b;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
    forever begin
      @(negedge swclk);
      hready = 1'b1; hresp = 1'b0;
      if (rst_n && htrans == 2'b10) begin
        if (bus_q.size() == 0) begin
          check("unexp_xfer", 32'(htrans), 32'd0);
        end else begin
          b = bus_q.pop_front();
          check("haddr", haddr, b.addr);
          check("hsize", 32'(hsize), 32'(b.size));
          check("hwrite", 32'(hwrite), 32'(b.wr));
          @(negedge swclk);
          if (!g_abort) begin
            check("htrans_data", 32'(htrans), 32'd0);
            check("rdy_low", 32'(ap_rdy), 32'd0);
          end
          for (int i = 0; i < b.ws; i++) begin
            hready = 1'b0; hresp = b.err;
            if (!g_abort && i > 0) check("rdy_wait", 32'(ap_rdy), 32'd0);
            if (!g_abort && b.wr) check("hwdata_wait", hwdata, b.wdata);
            @(negedge swclk);
          end
          hready = 1'b1; hresp = b.err;
          if (!b.wr) hrdata = b.rd;
          if (!g_abort && b.wr) check("hwdata", hwdata, b.wdata);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached with %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0; ap_sel = 8'd0; ap_addr = 6'd0; ap_wdata = 32'd0; ap_wen = 1'b0; ap_ren = 1'b0;
    #12;
    check("rst.rdy", 32'(ap_rdy), 32'd1);
    check("rst.err", 32'(ap_err), 32'd0);
    check("rst.rdata", ap_rdata, 32'd0);
    check("rst.htrans", 32'(htrans), 32'd0);
    check("rst.haddr", haddr, 32'd0);
    @(negedge swclk);
    rst_n = 1'b1;

    rd_loc("idr", 6'h3F, IDR);

    wr_loc("csw12", 6'h00, 32'h12);
    wr_loc("tar2k", 6'h01, 32'h2000_0000);
    push_bus(32'h2000_0000, 3'd2, 1'b1, 32'hA5, 0, 32'd0, 1'b0);
    do_req("drw_w0", APSEL, 6'h03, 1'b1, 32'hA5, m_rd, 1'b0, 1'b0);
    push_bus(32'h2000_0004, 3'd2, 1'b1, 32'h5A, 0, 32'd0, 1'b0);
    do_req("drw_w1", APSEL, 6'h03, 1'b1, 32'h5A, m_rd, 1'b0, 1'b0);
    rd_loc("tar_inc8", 6'h01, 32'h2000_0008);
    rd_loc("csw_rd", 6'h00, 32'h52);

    wr_loc("csw10", 6'h00, 32'h10);
    wr_loc("tar1003", 6'h01, 32'h0000_1003);
    push_bus(32'h0000_1003, 3'd0, 1'b0, 32'd0, 3, 32'h7700_0000, 1'b0);
    m_rd = 32'h7700_0000;
    do_req("drw_r_ws", APSEL, 6'h03, 1'b0, 32'd0, m_rd, 1'b0, 1'b0);
    rd_loc("tar1004", 6'h01, 32'h0000_1004);

    wr_loc("tar3k", 6'h01, 32'h3000_0010);
    push_bus(32'h3000_0018, 3'd2, 1'b0, 32'd0, 0, 32'hCAFE_0002, 1'b0);
    m_rd = 32'hCAFE_0002;
    do_req("bd2_r", APSEL, 6'h06, 1'b0, 32'd0, m_rd, 1'b0, 1'b0);
    rd_loc("tar_bd", 6'h01, 32'h3000_0010);
    do_req("badsel_w", APSEL + 8'd1, 6'h01, 1'b1, 32'h0000_dead, m_rd, 1'b0, 1'b1);
    do_req("badsel_drw", APSEL + 8'd1, 6'h03, 1'b0, 32'd0, m_rd, 1'b0, 1'b1);
    rd_loc("tar_badsel", 6'h01, 32'h3000_0010);

    wr_loc("csw12b", 6'h00, 32'h12);
    push_bus(32'h3000_0010, 3'd2, 1'b1, 32'h11, 1, 32'd0, 1'b1);
    do_req("drw_err", APSEL, 6'h03, 1'b1, 32'h11, m_rd, 1'b1, 1'b0);
    rd_loc("csw_clr", 6'h00, 32'h52);
    rd_loc("tar_noinc", 6'h01, 32'h3000_0010);

    wr_loc("csw17", 6'h00, 32'h17);
    rd_loc("csw_clamp", 6'h00, 32'h52);
    wr_loc("tarwrap", 6'h01, 32'hffff_fffc);
    push_bus(32'hffff_fffc, 3'd2, 1'b1, 32'h33, 0, 32'd0, 1'b0);
    do_req("drw_wrap", APSEL, 6'h03, 1'b1, 32'h33, m_rd, 1'b0, 1'b0);
    rd_loc("tar_wrap0", 6'h01, 32'h0);
    wr_loc("csw22", 6'h00, 32'h22);
    rd_loc("csw_inc_off", 6'h00, 32'h62);
    push_bus(32'h0, 3'd2, 1'b0, 32'd0, 0, 32'h1234, 1'b0);
    m_rd = 32'h1234;
    do_req("drw_noinc", APSEL, 6'h03, 1'b0, 32'd0, m_rd, 1'b0, 1'b0);
    rd_loc("tar_off", 6'h01, 32'h0);
    rd_loc("raz", 6'h02, 32'h0);
    rd_loc("cfg", 6'h3D, 32'h0);
    rd_loc("base", 6'h3E, BASE);

    wr_loc("csw12c", 6'h00, 32'h12);
    wr_loc("tar40", 6'h01, 32'h40);
    push_bus(32'h40, 3'd2, 1'b0, 32'd0, 6, 32'h0bad, 1'b0);
    ap_sel = APSEL; ap_addr = 6'h03; ap_ren = 1'b1;
    @(negedge swclk);
    ap_ren = 1'b0;
    @(negedge swclk);
    check("mid.rdy_low", 32'(ap_rdy), 32'd0);
    g_abort = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid.htrans", 32'(htrans), 32'd0);
    check("mid.rdy", 32'(ap_rdy), 32'd1);
    check("mid.haddr", haddr, 32'd0);
    check("mid.rdata", ap_rdata, 32'd0);
    m_rd = 32'd0;
    @(negedge swclk);
    rst_n = 1'b1;
    repeat (9) @(negedge swclk);
    g_abort = 1'b0;
    rd_loc("tar_rst", 6'h01, 32'h0);
    rd_loc("csw_rst", 6'h00, 32'h40);
    push_bus(32'h0, 3'd0, 1'b0, 32'd0, 0, 32'h55, 1'b0);
    m_rd = 32'h55;
    do_req("drw_fresh", APSEL, 6'h03, 1'b0, 32'd0, m_rd, 1'b0, 1'b0);

    repeat (3) @(negedge swclk);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/opendap_mem_ap_ahbl.md
OPENDAP_MEM_AP_AHBL -- requirements
Module: opendap_mem_ap_ahbl

Interface
REQ-001 SHALL have parameter APSEL, default 8'd0: the AP select value this AP responds to.
REQ-002 SHALL have parameter IDR, default 32'h0477_0001: the value returned by IDR reads.
REQ-003 SHALL have parameter BASE, default 32'hffff_ffff: the value returned by BASE reads.
REQ-004 SHALL have one clock and one asynchronous, active-low reset: swclk input 1, rising-edge clock for all state.
REQ-005 SHALL have rst_n input 1: asynchronous, active-low reset.
REQ-006 SHALL have ap_sel input 8: AP select from the DP.
REQ-007 SHALL have ap_addr input 6: AP register word index (AP byte address [7:2]).
REQ-008 SHALL have ap_wdata input 32: write data.
REQ-009 SHALL have ap_wen input 1 and ap_ren input 1: single-cycle write and read request strobes.
REQ-010 SHALL have ap_rdata output 32: last read result.
REQ-011 SHALL have ap_rdy output 1 (AP idle / last access complete) and ap_err output 1 (last access errored).
REQ-012 SHALL have the AHB-Lite master outputs haddr 32, htrans 2, hwrite 1, hsize 3 and hwdata 32.
REQ-013 SHALL have the AHB-Lite master inputs hrdata 32, hready 1 and hresp 1.

Function
REQ-014 A request SHALL be accepted only when ap_rdy=1 and (ap_wen|ap_ren), with ap_sel==APSEL.
  - Requests with ap_sel!=APSEL SHALL be ignored, with no state change.
  - Requests while ap_rdy=0 SHALL be ignored.
REQ-015 Register map by ap_addr index; all unlisted indices SHALL be RAZ/WI:
  - 0x00 CSW.
  - 0x01 TAR, 32-bit RW.
  - 0x03 DRW.
  - 0x04-0x07 BD0-BD3.
  - 0x3D CFG, reads 0.
  - 0x3E BASE.
  - 0x3F IDR.
REQ-016 CSW fields:
  - [2:0] Size RW. A write value >2 SHALL store 3'd2.
  - [5:4] AddrInc RW. Any value other than 2'b01 SHALL behave as "off".
  - [6] DeviceEn, reads 1.
  - [7] TrInProg, reads !ap_rdy.
  - All other bits RAZ/WI.
REQ-017 Reads of CSW, TAR, CFG, BASE, IDR and RAZ indices SHALL complete without bus activity.
  - ap_rdy SHALL stay 1.
  - ap_rdata SHALL update on the clock edge after acceptance.
  - ap_err SHALL be 0.
REQ-018 Accepted DRW or BDn accesses SHALL start an AHB transfer and drop ap_rdy on the next cycle.
REQ-019 The FSM SHALL have the states IDLE, ADDR and DATA:
  - IDLE -> ADDR on an accepted DRW/BD access.
  - ADDR -> DATA when hready=1.
  - DATA -> IDLE when hready=1.
REQ-020 In ADDR, the address-phase outputs SHALL be driven and held until hready=1:
  - htrans=2'b10 (NONSEQ).
  - DRW: haddr=TAR, hsize=CSW.Size.
  - BDn: haddr={TAR[31:4], n[1:0], 2'b00}, hsize=3'd2.
  - hwrite=ap_wen.
REQ-021 Outside ADDR, htrans SHALL be 2'b00.
REQ-022 hwdata SHALL equal the captured ap_wdata and be held stable throughout DATA.
  - No lane replication; the DP supplies lane-correct data.
REQ-023 On the DATA cycle where hready=1, the AP SHALL:
  - capture hrdata into ap_rdata (reads only);
  - set ap_err=hresp;
  - return ap_rdy to 1 on the next cycle.
REQ-024 After a DRW transfer completing with hresp=0 and AddrInc=01, TAR SHALL increment by (1<<Size) mod 2^32.
  - 32'hffff_fffc + 4 SHALL give 0.
  - There SHALL be no increment on error, for BDn accesses, or when AddrInc is off.
REQ-025 ap_err SHALL be cleared to 0 when the next request is accepted.
REQ-026 ap_rdata SHALL hold its value between reads; writes SHALL NOT alter it.
REQ-027 A write to TAR or CSW SHALL take effect for any DRW/BD access accepted on a later cycle.

Reset
REQ-028 When rst_n=0, the AP SHALL asynchronously force the following, including mid-transfer:
  - FSM=IDLE.
  - htrans=2'b00, haddr=0, hwrite=0, hsize=0, hwdata=0.
  - ap_rdata=0, ap_rdy=1, ap_err=0.
  - CSW.Size=0, AddrInc=0, TAR=0.
REQ-029 After reset release, the AP SHALL accept a request on the first rising edge.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Read IDR with ap_sel=APSEL -> ap_rdata=IDR next cycle, ap_rdy stays 1, htrans stays 0.
  - CSW=0x12, TAR=0x2000_0000, then two DRW writes 0xA5, 0x5A with hready=1 -> two NONSEQ writes, haddr 0x2000_0000 then 0x2000_0004, hsize=2, TAR finally 0x2000_0008.
  - CSW=0x10 (byte, inc), TAR=0x1003, DRW read with hready low 3 cycles in DATA, hrdata=0x7700_0000 -> ap_rdy low until completion, ap_rdata=0x7700_0000, TAR=0x1004.
  - BD2 read with TAR=0x3000_0010 -> haddr=0x3000_0018, hsize=2, TAR unchanged; request with ap_sel=APSEL+1 -> no effect.
  - DRW write with AHB two-cycle ERROR response -> ap_err=1, TAR not incremented; next CSW read clears ap_err.
  - rst_n low during DATA phase -> htrans=0, ap_rdy=1, TAR=0 immediately; a subsequent DRW read issues a fresh transfer at 0.
